// File: rtl/bird_pkg.sv
// Shared constants and types for the bird trajectory logic.
// FIXED_POINT_MULTIPLIER/FP_SHIFT define the x64 fixed-point format used for
// positions and speeds. DEFAULT_GRAVITY and DEFAULT_MAX_Y_SPEED match the
// constants used on the plane_move side.
package bird_pkg;

  localparam int FIXED_POINT_MULTIPLIER = 64;
  localparam int FP_SHIFT               = 6;

  localparam int DEFAULT_GRAVITY     = 8;
  localparam int DEFAULT_MAX_Y_SPEED = 640;

  typedef enum logic [1:0] {
    IDLE_ST,
    FLY_ST,
    LANDED_ST
  } bird_state_t;

endpackage

// File: rtl/rise_edge_detect.sv
// Registered rising-edge detector.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset
//   in    - level input (e.g. a keypad key)
//   pulse - one-cycle pulse, one cycle after the rising edge of in
module rise_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic in_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      in_q  <= in;
      pulse <= in & ~in_q;
    end
  end

endmodule

// File: rtl/bird_drop.sv
// Ballistic trajectory generator for the bird carried by the plane.
// Idle: tracks the plane anchor. On a release edge it detaches at the next frame, flies
// with the plane's horizontal speed and gravity-driven vertical speed, lands on the
// ground, a collision or the right despawn limit, holds LANDED_FRAMES frames, re-arms.
// Optional build macro: BIRD_BOUNCE_EN - fast ground crossings bounce instead of landing.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   startOfFrame      - one-cycle frame pulse
//   release_key       - keypad release level (named so because release is a reserved word)
//   birdStartX/Y      - plane-supplied anchor, pixels (signed)
//   x_speed           - plane horizontal speed, 1/64 px/frame
//   collisionBird     - bird pixel overlaps an object this cycle
//   topLeftX/Y        - registered bird position, pixels (signed)
//   bird_active       - high while in flight
//   bird_landed       - one-cycle pulse when a flight ends
module bird_drop
  import bird_pkg::*;
#(
  parameter int GRAVITY       = DEFAULT_GRAVITY,
  parameter int MAX_Y_SPEED   = DEFAULT_MAX_Y_SPEED,
  parameter int OFFSET_X      = 48,
  parameter int OFFSET_Y      = 40,
  parameter int Y_GROUND      = 416,
  parameter int X_RIGHT       = 608,
  parameter int LANDED_FRAMES = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               release_key,
  input  logic signed [10:0] birdStartX,
  input  logic signed [10:0] birdStartY,
  input  logic        [10:0] x_speed,
  input  logic               collisionBird,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               bird_active,
  output logic               bird_landed
);

  localparam logic signed [31:0] GroundFp = 32'(Y_GROUND * FIXED_POINT_MULTIPLIER);

  bird_state_t        state_q, state_d;
  logic signed [31:0] xpos_q, xpos_d;
  logic signed [31:0] ypos_q, ypos_d;
  logic signed [31:0] yspeed_q, yspeed_d;
  logic signed [31:0] xspeed_q, xspeed_d;
  logic               hit_q, hit_d;
  logic               rel_pend_q, rel_pend_d;
  logic        [15:0] cnt_q, cnt_d;

  logic               rel_edge;
  logic               land_evt;
  logic               hit_now;
  logic signed [31:0] anchor_x, anchor_y;
  logic signed [31:0] next_x, next_y;
  logic signed [31:0] yspeed_sum, yspeed_grav;

  rise_edge_detect u_rel_edge (
    .clk   (clk),
    .reset (reset),
    .in    (release_key),
    .pulse (rel_edge)
  );

  assign anchor_x    = (32'(birdStartX) + OFFSET_X) * FIXED_POINT_MULTIPLIER;
  assign anchor_y    = (32'(birdStartY) + OFFSET_Y) * FIXED_POINT_MULTIPLIER;
  assign next_x      = xpos_q + xspeed_q;
  assign next_y      = ypos_q + yspeed_q;
  assign yspeed_sum  = yspeed_q + GRAVITY;
  assign yspeed_grav = (yspeed_sum > MAX_Y_SPEED) ? MAX_Y_SPEED : yspeed_sum;
  // A collision coinciding with the frame pulse still counts for this frame.
  assign hit_now     = hit_q | collisionBird;

  always_comb begin
    state_d    = state_q;
    xpos_d     = xpos_q;
    ypos_d     = ypos_q;
    yspeed_d   = yspeed_q;
    xspeed_d   = xspeed_q;
    hit_d      = hit_q;
    rel_pend_d = rel_pend_q;
    cnt_d      = cnt_q;
    land_evt   = 1'b0;

    unique case (state_q)
      IDLE_ST: begin
        rel_pend_d = rel_pend_q | rel_edge;
        if (startOfFrame) begin
          xpos_d = anchor_x;
          ypos_d = anchor_y;
          // Uses the registered flag, so an edge arriving with this frame waits a frame.
          if (rel_pend_q) begin
            xspeed_d   = $signed({21'd0, x_speed});
            yspeed_d   = '0;
            rel_pend_d = 1'b0;
            state_d    = FLY_ST;
          end
        end
      end

      FLY_ST: begin
        hit_d = hit_now;
        if (startOfFrame) begin
          if (hit_now) begin
            state_d = LANDED_ST;
          end else if ((next_y >>> FP_SHIFT) >= Y_GROUND) begin
            ypos_d = GroundFp;
`ifdef BIRD_BOUNCE_EN
            if (yspeed_q >= 4 * GRAVITY) begin
              xpos_d   = next_x;
              yspeed_d = -(yspeed_q >>> 1);
            end else begin
              state_d = LANDED_ST;
            end
`else
            state_d = LANDED_ST;
`endif
          end else if ((next_x >>> FP_SHIFT) > X_RIGHT) begin
            state_d = LANDED_ST;
          end else begin
            xpos_d   = next_x;
            ypos_d   = next_y;
            yspeed_d = yspeed_grav;
          end

          if (state_d == LANDED_ST) begin
            land_evt = 1'b1;
            cnt_d    = '0;
          end
        end
      end

      LANDED_ST: begin
        if (startOfFrame) begin
          if (cnt_q == 16'(LANDED_FRAMES - 1)) begin
            hit_d   = 1'b0;
            state_d = IDLE_ST;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      default: state_d = IDLE_ST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE_ST;
      xpos_q      <= '0;
      ypos_q      <= '0;
      yspeed_q    <= '0;
      xspeed_q    <= '0;
      hit_q       <= 1'b0;
      rel_pend_q  <= 1'b0;
      cnt_q       <= '0;
      topLeftX    <= '0;
      topLeftY    <= '0;
      bird_active <= 1'b0;
      bird_landed <= 1'b0;
    end else begin
      state_q     <= state_d;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      yspeed_q    <= yspeed_d;
      xspeed_q    <= xspeed_d;
      hit_q       <= hit_d;
      rel_pend_q  <= rel_pend_d;
      cnt_q       <= cnt_d;
      topLeftX    <= 11'(xpos_q >>> FP_SHIFT);
      topLeftY    <= 11'(ypos_q >>> FP_SHIFT);
      bird_active <= (state_d == FLY_ST);
      bird_landed <= land_evt;
    end
  end

endmodule
